// File: rtl/ahb3lite_rr_master.sv
// ahb3lite_rr_master: round-robin arbiter that runs single AHB3-Lite
// transfers on behalf of NUM_REQ local requesters.
//
// Ports:
//   HCLK, HRESET          clock, synchronous active-high reset
//   req_valid/req_ready   per-requester command handshake (one-hot accept)
//   req_write/addr/wdata/size  packed per-requester command payload
//   rsp_valid             one-hot completion pulse
//   rsp_err, rsp_rdata    response status and read data
//   H*                    AHB3-Lite master signals
//
// Optional build macro AHB_RR_MASTER_TIMEOUT_EN adds a wait-state
// watchdog that aborts a transfer after TIMEOUT_CYCLES HREADY=0 cycles.
module ahb3lite_rr_master #(
    parameter int NUM_REQ        = 2,
    parameter int HADDR_SIZE     = 32,
    parameter int HDATA_SIZE     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           HCLK,
    input  logic                           HRESET,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*HADDR_SIZE-1:0]  req_addr,
    input  logic [NUM_REQ*HDATA_SIZE-1:0]  req_wdata,
    input  logic [NUM_REQ*3-1:0]           req_size,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic                           rsp_err,
    output logic [HDATA_SIZE-1:0]          rsp_rdata,
    output logic                           HSEL,
    output logic [HADDR_SIZE-1:0]          HADDR,
    output logic                           HWRITE,
    output logic [2:0]                     HSIZE,
    output logic [2:0]                     HBURST,
    output logic [3:0]                     HPROT,
    output logic [1:0]                     HTRANS,
    output logic [HDATA_SIZE-1:0]          HWDATA,
    input  logic [HDATA_SIZE-1:0]          HRDATA,
    input  logic                           HREADY,
    input  logic                           HRESP
);

    localparam int LW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int MAXSZ = $clog2(HDATA_SIZE / 8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_LERR
    } state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         last_q, last_d;
    logic [LW-1:0]         gnt_q, gnt_d;
    logic [HADDR_SIZE-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [HDATA_SIZE-1:0] wdata_q, wdata_d;
    logic [2:0]            size_q, size_d;
    logic [HDATA_SIZE-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;

`ifdef AHB_RR_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]         wait_q, wait_d;
`endif

    logic                  gnt_found;
    logic [LW-1:0]         gnt_idx;
    logic [HADDR_SIZE-1:0] sel_addr;
    logic [HDATA_SIZE-1:0] sel_wdata;
    logic [2:0]            sel_size;
    logic                  sel_write;
    logic [HADDR_SIZE-1:0] align_mask;
    logic                  sel_legal;

    // Search starts just after the last winner and wraps around.
    always_comb begin : arb
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = LW'(idx);
            end
        end
    end

    assign sel_addr   = req_addr[gnt_idx*HADDR_SIZE +: HADDR_SIZE];
    assign sel_wdata  = req_wdata[gnt_idx*HDATA_SIZE +: HDATA_SIZE];
    assign sel_size   = req_size[gnt_idx*3 +: 3];
    assign sel_write  = req_write[gnt_idx];
    assign align_mask = (HADDR_SIZE'(1) << sel_size) - HADDR_SIZE'(1);
    assign sel_legal  = (sel_size <= 3'(MAXSZ)) &&
                        ((sel_addr & align_mask) == '0);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        done_d    = 1'b0;
        req_ready = '0;
`ifdef AHB_RR_MASTER_TIMEOUT_EN
        wait_d    = '0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    req_ready[gnt_idx] = 1'b1;
                    last_d  = gnt_idx;
                    gnt_d   = gnt_idx;
                    addr_d  = sel_addr;
                    write_d = sel_write;
                    wdata_d = sel_write ? sel_wdata : '0;
                    size_d  = sel_size;
                    if (sel_legal) begin
                        state_d = S_ADDR;
                    end else begin
                        // Rejected locally; the bus never sees it.
                        state_d = S_LERR;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                // An ERROR response's first cycle has HREADY=0,
                // so it simply waits here like a wait state.
                if (HREADY) begin
                    rdata_d = write_q ? '0 : HRDATA;
                    err_d   = HRESP;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_LERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef AHB_RR_MASTER_TIMEOUT_EN
        if ((state_q == S_ADDR || state_q == S_DATA) && !HREADY) begin
            if (wait_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                err_d   = 1'b1;
                rdata_d = '0;
            end else begin
                wait_d = wait_q + TW'(1);
            end
        end
`endif
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            last_q  <= LW'(NUM_REQ - 1);
            gnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            size_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef AHB_RR_MASTER_TIMEOUT_EN
            wait_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            done_q  <= done_d;
`ifdef AHB_RR_MASTER_TIMEOUT_EN
            wait_q  <= wait_d;
`endif
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (done_q || state_q == S_LERR) begin
            rsp_valid[gnt_q] = 1'b1;
        end
    end

    assign rsp_err   = err_q;
    assign rsp_rdata = rdata_q;

    assign HSEL   = (state_q == S_ADDR);
    assign HTRANS = (state_q == S_ADDR) ? 2'b10 : 2'b00;
    assign HADDR  = addr_q;
    assign HWRITE = write_q;
    assign HSIZE  = size_q;
    assign HBURST = 3'b000;
    assign HPROT  = 4'b0011;
    assign HWDATA = wdata_q;

endmodule

// File: tb/tb_ahb3lite_rr_master.sv
// tb_ahb3lite_rr_master: directed and randomized single-transfer checks
// of ahb3lite_rr_master with the bench acting as the AHB slave.
module tb_ahb3lite_rr_master;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            HCLK = 1'b0;
    logic            HRESET;
    logic [N-1:0]    req_valid, req_ready, req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*3-1:0]  req_size;
    logic [N-1:0]    rsp_valid;
    logic            rsp_err;
    logic [DW-1:0]   rsp_rdata;
    logic            HSEL, HWRITE, HREADY, HRESP;
    logic [AW-1:0]   HADDR;
    logic [2:0]      HSIZE, HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic [DW-1:0]   HWDATA, HRDATA;

    int errors = 0;
    int checks = 0;

    always #5 HCLK = ~HCLK;

    ahb3lite_rr_master #(
        .NUM_REQ(N), .HADDR_SIZE(AW), .HDATA_SIZE(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        @(negedge HCLK);
        chk({tag, "_htrans"}, 64'(HTRANS), 64'd0);
        chk({tag, "_hsel"},   64'(HSEL),   64'd0);
        chk({tag, "_haddr"},  64'(HADDR),  64'd0);
        chk({tag, "_hwrite"}, 64'(HWRITE), 64'd0);
        chk({tag, "_hsize"},  64'(HSIZE),  64'd0);
        chk({tag, "_hburst"}, 64'(HBURST), 64'd0);
        chk({tag, "_hprot"},  64'(HPROT),  64'd3);
        chk({tag, "_hwdata"}, 64'(HWDATA), 64'd0);
        chk({tag, "_rdy"},    64'(req_ready), 64'd0);
        chk({tag, "_rvld"},   64'(rsp_valid), 64'd0);
    endtask

    task automatic set_req(input int r, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] sz);
        req_valid[r]          = 1'b1;
        req_write[r]          = wr;
        req_addr[r*AW +: AW]  = a;
        req_wdata[r*DW +: DW] = wd;
        req_size[r*3 +: 3]    = sz;
    endtask

    // One complete transaction from requester r; aw/dw are the slave's
    // address- and data-phase wait states, er requests an ERROR response.
    task automatic xfer(input int r, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] sz,
                        input int aw, input int dw, input bit er,
                        input logic [31:0] rd);
        bit legal;
        int nd;
        logic [63:0] onehot;
        legal  = (sz <= 3'd2) && ((a % (32'd1 << sz)) == 0);
        onehot = 64'd1 << r;
        req_valid = '0;
        set_req(r, wr, a, wd, sz);
        HREADY = 1'b1;
        HRESP  = 1'b0;
        @(negedge HCLK);
        chk("gnt", 64'(req_ready), onehot);
        chk("gnt_htrans", 64'(HTRANS), 64'd0);
        next_cycle();
        req_valid = '0;
        if (!legal) begin
            @(negedge HCLK);
            chk("lerr_htrans", 64'(HTRANS), 64'd0);
            chk("lerr_vld", 64'(rsp_valid), onehot);
            chk("lerr_err", 64'(rsp_err), 64'd1);
            chk("lerr_data", 64'(rsp_rdata), 64'd0);
            next_cycle();
            @(negedge HCLK);
            chk("lerr_after", 64'(rsp_valid), 64'd0);
            chk("lerr_after_htrans", 64'(HTRANS), 64'd0);
            next_cycle();
        end else begin
            for (int j = 0; j <= aw; j++) begin
                HREADY = (j == aw);
                @(negedge HCLK);
                chk("a_htrans", 64'(HTRANS), 64'd2);
                chk("a_hsel",   64'(HSEL),   64'd1);
                chk("a_haddr",  64'(HADDR),  64'(a));
                chk("a_hwrite", 64'(HWRITE), 64'(wr));
                chk("a_hsize",  64'(HSIZE),  64'(sz));
                chk("a_rvld",   64'(rsp_valid), 64'd0);
                next_cycle();
            end
            nd = dw + (er ? 1 : 0);
            for (int j = 0; j <= nd; j++) begin
                HREADY = (j == nd);
                HRESP  = er && (j >= dw);
                HRDATA = rd;
                @(negedge HCLK);
                chk("d_htrans", 64'(HTRANS), 64'd0);
                chk("d_hsel",   64'(HSEL),   64'd0);
                chk("d_haddr",  64'(HADDR),  64'(a));
                chk("d_hwrite", 64'(HWRITE), 64'(wr));
                if (wr) chk("d_hwdata", 64'(HWDATA), 64'(wd));
                chk("d_rvld",   64'(rsp_valid), 64'd0);
                next_cycle();
            end
            HREADY = 1'b1;
            HRESP  = 1'b0;
            HRDATA = $urandom;
            @(negedge HCLK);
            chk("rsp_vld",  64'(rsp_valid), onehot);
            chk("rsp_err",  64'(rsp_err),   64'(er));
            chk("rsp_data", 64'(rsp_rdata), wr ? 64'd0 : 64'(rd));
            next_cycle();
        end
    endtask

    initial begin
        logic [1:0]  nv;
        logic [63:0] exp_q[$];
        logic [63:0] e;
        int          ng, nr;
        int          rr, ksel, raw, rdw;
        bit          rwr, rer;
        logic [2:0]  rsz;
        logic [31:0] ra;

        HRESET    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_size  = '0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        repeat (2) next_cycle();
        chk_reset_outputs("rst");
        chk("rst_err",  64'(rsp_err),   64'd0);
        chk("rst_data", 64'(rsp_rdata), 64'd0);
        next_cycle();
        HRESET = 1'b0;

        // Both requesters hold two reads each; grants must alternate.
        HRDATA = 32'h1122_3344;
        set_req(0, 1'b0, 32'h10, 32'h0, 3'd2);
        set_req(1, 1'b0, 32'h20, 32'h0, 3'd2);
        req_valid = 2'b11;
        ng = 0;
        nr = 0;
        for (int cyc = 0; cyc < 20 && nr < 4; cyc++) begin
            nv = req_valid;
            @(negedge HCLK);
            if (req_ready != '0) begin
                e = (ng % 2 == 0) ? 64'd1 : 64'd2;
                chk("rr_gnt", 64'(req_ready), e);
                chk("rr_gnt_cycle", 64'(cyc), 64'(3 * ng));
                exp_q.push_back(e);
                if (ng >= 2) nv = nv & ~req_ready;
                ng++;
            end
            if (rsp_valid != '0) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'd0;
                chk("rr_rsp", 64'(rsp_valid), e);
                chk("rr_data", 64'(rsp_rdata), 64'h1122_3344);
                chk("rr_err", 64'(rsp_err), 64'd0);
                nr++;
            end
            next_cycle();
            req_valid = nv;
        end
        chk("rr_grants", 64'(ng), 64'd4);
        chk("rr_rsps", 64'(nr), 64'd4);
        req_valid = '0;

        xfer(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 3'd2, 0, 0, 1'b0, 32'h0);
        xfer(0, 1'b0, 32'h200, 32'h0, 3'd2, 0, 3, 1'b0, 32'hCAFE_F00D);
        xfer(1, 1'b0, 32'h300, 32'h0, 3'd2, 0, 0, 1'b1, 32'h5555_AAAA);
        xfer(1, 1'b1, 32'h304, 32'h1234_5678, 3'd2, 1, 1, 1'b0, 32'h0);
        xfer(0, 1'b0, 32'h102, 32'h0, 3'd2, 0, 0, 1'b0, 32'h0);
        xfer(1, 1'b0, 32'h108, 32'h0, 3'd3, 0, 0, 1'b0, 32'h0);

        for (int t = 0; t < 40; t++) begin
            rr   = int'($urandom_range(0, 1));
            rwr  = 1'($urandom_range(0, 1));
            ksel = int'($urandom_range(0, 9));
            rsz  = 3'($urandom_range(0, 2));
            ra   = $urandom;
            if (ksel == 0) begin
                rsz = 3'd3;
            end else if (ksel == 1) begin
                rsz = 3'd2;
                ra  = ra | 32'd1;
            end else begin
                ra = ra & ~((32'd1 << rsz) - 32'd1);
            end
            raw = int'($urandom_range(0, 2));
            rdw = int'($urandom_range(0, 3));
            rer = ($urandom_range(0, 3) == 0);
            xfer(rr, rwr, ra, $urandom, rsz, raw, rdw, rer, $urandom);
        end

        // Reset while the data phase is stalled.
        xfer(0, 1'b0, 32'h40, 32'h0, 3'd2, 0, 0, 1'b0, 32'h0BAD_CAFE);
        req_valid = '0;
        set_req(0, 1'b1, 32'h400, 32'hA5A5_A5A5, 3'd2);
        @(negedge HCLK);
        chk("rw_gnt", 64'(req_ready), 64'd1);
        next_cycle();
        req_valid = '0;
        @(negedge HCLK);
        chk("rw_addr", 64'(HTRANS), 64'd2);
        next_cycle();
        HREADY = 1'b0;
        @(negedge HCLK);
        chk("rw_data", 64'(HWDATA), 64'hA5A5_A5A5);
        next_cycle();
        HRESET = 1'b1;
        @(negedge HCLK);
        next_cycle();
        HRESET = 1'b0;
        HREADY = 1'b1;
        chk_reset_outputs("mid");
        next_cycle();
        @(negedge HCLK);
        chk("mid_norsp", 64'(rsp_valid), 64'd0);
        next_cycle();

        xfer(1, 1'b0, 32'h500, 32'h0, 3'd2, 0, 0, 1'b0, 32'h7777_0001);
        set_req(0, 1'b0, 32'h600, 32'h0, 3'd2);
        set_req(1, 1'b0, 32'h700, 32'h0, 3'd2);
        req_valid = 2'b11;
        @(negedge HCLK);
        chk("both_gnt", 64'(req_ready), 64'd1);
        next_cycle();
        req_valid = '0;
        @(negedge HCLK);
        chk("both_haddr", 64'(HADDR), 64'h600);
        next_cycle();
        HRDATA = 32'h0F0F_F0F0;
        @(negedge HCLK);
        next_cycle();
        @(negedge HCLK);
        chk("both_rsp", 64'(rsp_valid), 64'd1);
        chk("both_data", 64'(rsp_rdata), 64'h0F0F_F0F0);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb3lite_rr_master.md
Name: ahb3lite_rr_master

Overview:
- Round-robin arbiter and sequencer that lets NUM_REQ local requesters share one AHB3-Lite master port.
- Accepts single read/write commands, runs each as an AHB SINGLE transfer (address phase, then data phase with HREADY wait states and HRESP error), and returns a per-requester response.
- Sits between on-chip command sources and the AHB3-Lite slave side of the bus interface.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- HADDR_SIZE, 32, AHB address width.
- HDATA_SIZE, 32, AHB data width (32 or 64).
- TIMEOUT_CYCLES, 16, wait-state limit; used only with the optional feature.

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- req_write  in  NUM_REQ  1 = write.
- req_addr  in  NUM_REQ*HADDR_SIZE  packed addresses; requester i at [i*HADDR_SIZE +: HADDR_SIZE].
- req_wdata  in  NUM_REQ*HDATA_SIZE  packed write data.
- req_size  in  NUM_REQ*3  packed HSIZE encodings.
- rsp_valid  out  NUM_REQ  one-hot completion pulse.
- rsp_err  out  1  error flag, qualified by rsp_valid.
- rsp_rdata  out  HDATA_SIZE  read data, qualified by rsp_valid.
- HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HWDATA  out  AHB widths  AHB master outputs.
- HRDATA  in  HDATA_SIZE  AHB read data.
- HREADY  in  1  AHB ready.
- HRESP  in  1  AHB response (1 = ERROR).

Behaviour:
- Reset values:
  - All outputs 0.
  - HTRANS=IDLE (2'b00), HBURST=3'b000, HPROT=4'b0011.
  - FSM=IDLE; round-robin pointer last=NUM_REQ-1, so requester 0 wins first.
- Arbitration (IDLE only):
  - Grant g is the first index with req_valid set, searching from last+1 upward and wrapping modulo NUM_REQ.
  - The grant cycle raises req_ready[g] for exactly one cycle.
  - On that cycle, addr/write/wdata/size of g are captured and last is set to g.
  - No grant in any other state; req_ready stays 0.
- Legality check at grant:
  - A request is illegal if size > log2(HDATA_SIZE/8), or if addr is not aligned to 2^size.
  - Illegal request: FSM goes to LERR, no bus activity.
  - LERR lasts one cycle: rsp_valid[g]=1, rsp_err=1, rsp_rdata=0, then back to IDLE.
- ADDR state:
  - Drives HSEL=1, HTRANS=NONSEQ (2'b10), plus HADDR, HWRITE, HSIZE from the captured values.
  - Held stable until a cycle with HREADY=1, then goes to DATA.
- DATA state:
  - Drives HTRANS=IDLE and HSEL=0.
  - HWDATA = captured wdata for writes, stable for the whole data phase.
  - Each cycle with HREADY=0 and HRESP=0 holds DATA.
  - HREADY=1 completes the transfer:
    - rsp_rdata <= HRDATA (reads only; writes return 0).
    - rsp_err <= HRESP.
    - The next cycle pulses rsp_valid[g] for one cycle and the FSM returns to IDLE.
  - HRESP=1 with HREADY=0 (first ERROR cycle): stay in DATA, HTRANS stays IDLE, wait for the second cycle (HREADY=1), which completes with rsp_err=1.
- Latency (zero wait states):
  - Grant at cycle 0, ADDR at cycle 1, DATA at cycle 2, rsp_valid at cycle 3.
  - Cycle 3 is IDLE and may grant again, giving one transfer per 3 cycles.
- Simultaneous events:
  - A new req_valid arriving on the rsp_valid cycle may be granted on that same cycle.
  - The response and the accept are independent one-hot vectors.
- Requesters must hold req_valid and payload until req_ready. Dropping req_valid before grant is legal and simply not served.
- HRESET mid-transfer:
  - Next edge forces reset values and the FSM goes to IDLE.
  - The in-flight response is dropped (no rsp_valid) and the pointer returns to NUM_REQ-1.

Optional Feature:
- Macro: AHB_RR_MASTER_TIMEOUT_EN.
- When defined:
  - A wait counter counts consecutive HREADY=0 cycles in ADDR or DATA.
  - When it reaches TIMEOUT_CYCLES, the FSM aborts to IDLE, drives HTRANS=IDLE and HSEL=0, and pulses rsp_valid[g] with rsp_err=1 and rsp_rdata=0.
  - The counter clears on HREADY=1 or on a state change.
- When undefined: no counter, and wait states are unbounded.

Test Plan:
- Req0 write addr=0x100, data=0xDEADBEEF, size=2; zero wait states -> req_ready[0] at cycle 0; HTRANS=2'b10/HADDR=0x100 at cycle 1; HWDATA=0xDEADBEEF at cycle 2; rsp_valid=2'b01, rsp_err=0 at cycle 3.
- Req0 and req1 both hold valid for 4 reads from reset -> grants alternate 0,1,0,1; HRDATA=0x11223344 is returned on rsp_rdata with the matching one-hot rsp_valid.
- Read addr=0x200, slave inserts 3 HREADY=0 cycles in data phase -> HADDR/HWRITE unchanged, HTRANS=IDLE throughout; rsp_valid arrives 3 cycles later than the zero-wait case, with the correct data.
- Slave returns HRESP=1,HREADY=0 then HRESP=1,HREADY=1 -> rsp_err=1 with rsp_valid one cycle after the second ERROR cycle; next grant proceeds normally.
- Requests size=2 addr=0x102, and size=3 on a 32-bit bus -> no NONSEQ on the bus; rsp_valid+rsp_err=1 one cycle after req_ready.
- HRESET asserted during DATA wait -> next cycle all AHB outputs are at reset values and no rsp_valid; after release, req1 alone is granted first, and requester 0 wins when both are pending.
